// File: rtl/sp_sequencer.sv
// Stack-pointer sequencer: decodes NOP/PUSH/POP/LOAD words and issues one stack RAM beat per cycle
// within the [SP_BOTTOM, SP_TOP] window, reporting overflow/underflow/range errors.
module sp_sequencer #(
  parameter int AW = 32,
  parameter int STEP_LG2 = 2,
  parameter logic [AW-1:0] SP_TOP = AW'(32'h0000_1000),
  parameter logic [AW-1:0] SP_BOTTOM = AW'(32'h0000_0800)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   wlord,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          err_clr,
  output logic [AW-1:0] sp_out,
  output logic [AW-1:0] depth_out,
  output logic [AW-1:0] addr_out,
  output logic          addr_valid,
  output logic          is_push,
  output logic          ovf,
  output logic          unf,
  output logic          range_err,
  output logic          err_sticky
);

  // state  | meaning
  // S_IDLE | ready for a new instruction
  // S_PUSH | write burst in progress, rem beats still to issue
  // S_POP  | read burst in progress, rem beats still to issue
  typedef enum logic [1:0] {S_IDLE, S_PUSH, S_POP} state_t;

  localparam logic [AW:0]   STEP_X   = {{AW{1'b0}}, 1'b1} << STEP_LG2;
  localparam logic [AW-1:0] ONE      = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] STEP     = ONE << STEP_LG2;
  localparam logic [AW-1:0] LOW_MASK = STEP - ONE;
  localparam logic [AW:0]   BOT_X    = {1'b0, SP_BOTTOM};
  localparam logic [AW:0]   TOP_X    = {1'b0, SP_TOP};

  state_t        state;
  logic [3:0]    rem;
  logic [AW-1:0] sp;

  logic [1:0]    op;
  logic [3:0]    cnt;
  logic [25:0]   imm;
  logic          accept;
  logic [AW:0]   sp_x;
  logic          push_ok;
  logic          pop_ok;
  logic [AW-1:0] sp_dec;
  logic [AW-1:0] sp_inc;
  logic [AW-1:0] load_v;
  logic          load_ok;
  logic [3:0]    beat_cnt;
  logic          beat_push;
  logic          do_beat;

  function automatic logic [AW-1:0] depth_of(input logic [AW-1:0] s);
    return (SP_TOP - s) >> STEP_LG2;
  endfunction

  assign instr_ready = (state == S_IDLE);

  always_comb begin
    op        = wlord[31:30];
    cnt       = wlord[29:26];
    imm       = wlord[25:0];
    accept    = instr_valid && (state == S_IDLE);
    sp_x      = {1'b0, sp};
    push_ok   = sp_x >= (BOT_X + STEP_X);
    pop_ok    = (sp_x + STEP_X) <= TOP_X;
    sp_dec    = sp - STEP;
    sp_inc    = sp + STEP;
    load_v    = AW'(imm) & ~LOW_MASK;
    load_ok   = (load_v >= SP_BOTTOM) && (load_v <= SP_TOP);
    beat_cnt  = (state == S_IDLE) ? cnt : rem;
    beat_push = (state == S_IDLE) ? (op == 2'b01) : (state == S_PUSH);
    if (state == S_IDLE)
      do_beat = accept && (op == 2'b01 || op == 2'b10) && (cnt != 4'd0);
    else
      do_beat = (rem != 4'd0);
  end

  // sp runs one beat ahead of sp_out so the beat address and the post-beat SP land in consecutive cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rem        <= '0;
      sp         <= SP_TOP;
      sp_out     <= SP_TOP;
      depth_out  <= '0;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      is_push    <= 1'b0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      range_err  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      addr_valid <= 1'b0;
      is_push    <= 1'b0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      range_err  <= 1'b0;
      sp_out     <= sp;
      depth_out  <= depth_of(sp);
      err_sticky <= (err_sticky & ~err_clr) | ovf | unf | range_err;

      if (state != S_IDLE && rem == 4'd0)
        state <= S_IDLE;

      if (accept && op == 2'b11) begin
        if (load_ok) begin
          sp        <= load_v;
          sp_out    <= load_v;
          depth_out <= depth_of(load_v);
        end else begin
          range_err <= 1'b1;
        end
      end

      if (do_beat) begin
        state <= beat_push ? S_PUSH : S_POP;
        if (beat_push) begin
          if (push_ok) begin
            sp         <= sp_dec;
            addr_out   <= sp_dec;
            addr_valid <= 1'b1;
            is_push    <= 1'b1;
            rem        <= beat_cnt - 4'd1;
          end else begin
            ovf <= 1'b1;
            rem <= '0;
          end
        end else begin
          if (pop_ok) begin
            sp         <= sp_inc;
            addr_out   <= sp;
            addr_valid <= 1'b1;
            rem        <= beat_cnt - 4'd1;
          end else begin
            unf <= 1'b1;
            rem <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sp_sequencer.sv
// Bench for sp_sequencer: directed vector table, hand-written corner sequences and a randomized run
// against a transaction-level model that precomputes each instruction's per-cycle outputs.
module tb_sp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wlord;
  logic        instr_valid;
  logic        instr_ready;
  logic        err_clr;
  logic [31:0] sp_out, depth_out, addr_out;
  logic        addr_valid, is_push, ovf, unf, range_err, err_sticky;

  int checks = 0;
  int errors = 0;

  sp_sequencer dut (
    .clk(clk), .rst(rst), .wlord(wlord), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .err_clr(err_clr), .sp_out(sp_out),
    .depth_out(depth_out), .addr_out(addr_out), .addr_valid(addr_valid),
    .is_push(is_push), .ovf(ovf), .unf(unf), .range_err(range_err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; instr_valid = 1'b0; err_clr = 1'b0; wlord = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // drive one instruction for one cycle; returns at the negedge of the cycle after accept
  task automatic send(input logic [31:0] w);
    wlord = w; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; wlord = $urandom;
  endtask

  typedef struct {
    logic [31:0] wlord;
    logic [31:0] sp;
    int          beats;
    bit          err;
  } vec_t;

  typedef struct {
    bit          ready;
    bit          av;
    bit          ip;
    bit          ovf;
    bit          unf;
    bit          rerr;
    logic [31:0] addr;
    logic [31:0] sp;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_sp;
  bit          m_sticky;

  function automatic exp_t rec(input bit ready, input logic [31:0] s);
    exp_t r;
    r.ready = ready; r.av = 0; r.ip = 0; r.ovf = 0; r.unf = 0; r.rerr = 0;
    r.addr = '0; r.sp = s;
    return r;
  endfunction

  // whole-instruction outcome computed up front, one record per cycle after accept
  function automatic void model_instr(input logic [31:0] w);
    int   s;
    int   n;
    bit   stop;
    exp_t r;
    logic [31:0] v;
    s = int'(m_sp);
    n = int'(w[29:26]);
    stop = 0;
    case (w[31:30])
      2'b11: begin
        v = {6'b0, w[25:0]} & ~32'h3;
        if (v >= 32'h800 && v <= 32'h1000) m_sp = v;
        else begin r = rec(1, m_sp); r.rerr = 1; q.push_back(r); end
      end
      2'b01, 2'b10: begin
        for (int k = 0; k < n && !stop; k++) begin
          r = rec(0, 32'(s));
          if (w[31:30] == 2'b01) begin
            if (s - 4 >= 'h800) begin r.av = 1; r.ip = 1; r.addr = 32'(s - 4); s -= 4; end
            else begin r.ovf = 1; stop = 1; end
          end else begin
            if (s + 4 <= 'h1000) begin r.av = 1; r.addr = 32'(s); s += 4; end
            else begin r.unf = 1; stop = 1; end
          end
          q.push_back(r);
        end
        m_sp = 32'(s);
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] gen_word();
    int r;
    logic [1:0]  op;
    logic [3:0]  cnt;
    logic [25:0] imm;
    r = $urandom_range(0, 99);
    op = (r < 35) ? 2'b01 : (r < 70) ? 2'b10 : (r < 90) ? 2'b11 : 2'b00;
    cnt = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 5));
    if ($urandom_range(0, 7) == 0) imm = 26'($urandom);
    else imm = 26'($urandom_range('h7F0, 'h1010));
    return {op, cnt, imm};
  endfunction

  vec_t vecs[12];

  initial begin
    exp_t cur;
    int   beats;
    bit   err;
    bit   done;

    vecs[0]  = '{32'h4C00_0000, 32'hFF4, 3, 0};
    vecs[1]  = '{32'h8800_0000, 32'hFFC, 2, 0};
    vecs[2]  = '{32'hC000_0807, 32'h804, 0, 0};
    vecs[3]  = '{32'h4C00_0000, 32'h800, 1, 1};
    vecs[4]  = '{32'hC000_2000, 32'h800, 0, 1};
    vecs[5]  = '{32'hC000_1000, 32'h1000, 0, 0};
    vecs[6]  = '{32'h8400_0000, 32'h1000, 0, 1};
    vecs[7]  = '{32'h0000_0000, 32'h1000, 0, 0};
    vecs[8]  = '{32'h4000_0000, 32'h1000, 0, 0};
    vecs[9]  = '{32'hC000_07FC, 32'h1000, 0, 1};
    vecs[10] = '{32'hC000_0800, 32'h800, 0, 0};
    vecs[11] = '{32'hBC00_0000, 32'h83C, 15, 0};

    // reset values
    reset_dut();
    chk("rst_sp", sp_out, 32'h1000);
    chk("rst_depth", depth_out, 0);
    chk("rst_av", addr_valid, 0);
    chk("rst_addr", addr_out, 0);
    chk("rst_ip", is_push, 0);
    chk("rst_pulses", {ovf, unf, range_err}, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_ready", instr_ready, 1);

    // PUSH 3 then POP 2, cycle by cycle
    send(32'h4C00_0000);
    chk("push_b1_av", addr_valid, 1); chk("push_b1_addr", addr_out, 32'hFFC);
    chk("push_b1_ip", is_push, 1);    chk("push_b1_ready", instr_ready, 0);
    chk("push_b1_sp", sp_out, 32'h1000);
    @(negedge clk);
    chk("push_b2_addr", addr_out, 32'hFF8); chk("push_b2_sp", sp_out, 32'hFFC);
    @(negedge clk);
    chk("push_b3_addr", addr_out, 32'hFF4); chk("push_b3_av", addr_valid, 1);
    @(negedge clk);
    chk("push_end_ready", instr_ready, 1); chk("push_end_av", addr_valid, 0);
    chk("push_end_sp", sp_out, 32'hFF4);   chk("push_end_depth", depth_out, 3);
    send(32'h8800_0000);
    chk("pop_b1_addr", addr_out, 32'hFF4); chk("pop_b1_ip", is_push, 0);
    chk("pop_b1_av", addr_valid, 1);
    @(negedge clk);
    chk("pop_b2_addr", addr_out, 32'hFF8); chk("pop_b2_ip", is_push, 0);
    @(negedge clk);
    chk("pop_end_sp", sp_out, 32'hFFC); chk("pop_end_depth", depth_out, 1);
    chk("pop_end_ready", instr_ready, 1);

    // vector table from reset
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].wlord);
      beats = 0; err = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        if (addr_valid) beats++;
        if (ovf | unf | range_err) err = 1;
        if (instr_ready) done = 1;
        else @(negedge clk);
      end
      chk($sformatf("vec%0d_done", i), done, 1);
      chk($sformatf("vec%0d_sp", i), sp_out, vecs[i].sp);
      chk($sformatf("vec%0d_depth", i), depth_out, (32'h1000 - vecs[i].sp) >> 2);
      chk($sformatf("vec%0d_beats", i), beats, vecs[i].beats);
      chk($sformatf("vec%0d_err", i), err, vecs[i].err);
    end

    // overflow mid-burst and sticky error handling
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_sticky0", err_sticky, 0);
    send(32'hC000_0807);
    chk("ld_sp", sp_out, 32'h804); chk("ld_rerr", range_err, 0);
    send(32'h4C00_0000);
    chk("ovf_b1_addr", addr_out, 32'h800); chk("ovf_b1_av", addr_valid, 1);
    @(negedge clk);
    chk("ovf_pulse", ovf, 1); chk("ovf_noav", addr_valid, 0);
    chk("ovf_ready", instr_ready, 0);
    @(negedge clk);
    chk("ovf_idle", instr_ready, 1); chk("ovf_gone", ovf, 0);
    chk("ovf_sp", sp_out, 32'h800); chk("ovf_sticky", err_sticky, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_sticky", err_sticky, 0);

    // underflow and range error from reset
    reset_dut();
    send(32'h8400_0000);
    chk("unf_pulse", unf, 1); chk("unf_noav", addr_valid, 0);
    @(negedge clk);
    chk("unf_sp", sp_out, 32'h1000); chk("unf_ready", instr_ready, 1);
    send(32'hC000_2000);
    chk("rerr_pulse", range_err, 1); chk("rerr_sp", sp_out, 32'h1000);
    chk("rerr_ready", instr_ready, 1);

    // NOP / cnt=0 stream back to back
    for (int i = 0; i < 10; i++) begin
      wlord = {($urandom_range(0, 2) == 0) ? 2'b00 : ($urandom_range(0, 1) ? 2'b01 : 2'b10),
               4'h0, 26'($urandom)};
      instr_valid = 1'b1;
      @(negedge clk);
      chk("nop_ready", instr_ready, 1);
      chk("nop_av", addr_valid, 0);
    end
    instr_valid = 1'b0;

    // reset during beat 2 of PUSH 8
    reset_dut();
    send(32'h6000_0000);
    @(negedge clk);
    chk("mid_b2_av", addr_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_sp", sp_out, 32'h1000); chk("mid_av", addr_valid, 0);
    chk("mid_ready", instr_ready, 1);
    send(32'h4400_0000);
    chk("mid_push_addr", addr_out, 32'hFFC); chk("mid_push_av", addr_valid, 1);
    @(negedge clk);

    // randomized run against the model
    reset_dut();
    m_sp = 32'h1000; m_sticky = 0; q.delete();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      cur = (q.size() > 0) ? q.pop_front() : rec(1, m_sp);
      chk("rnd_ready", instr_ready, cur.ready);
      chk("rnd_av", addr_valid, cur.av);
      if (cur.av) begin
        chk("rnd_addr", addr_out, cur.addr);
        chk("rnd_ip", is_push, cur.ip);
      end
      chk("rnd_ovf", ovf, cur.ovf);
      chk("rnd_unf", unf, cur.unf);
      chk("rnd_rerr", range_err, cur.rerr);
      chk("rnd_sp", sp_out, cur.sp);
      chk("rnd_depth", depth_out, (32'h1000 - cur.sp) >> 2);
      chk("rnd_sticky", err_sticky, m_sticky);
      instr_valid = ($urandom_range(0, 9) < 6);
      err_clr = ($urandom_range(0, 19) == 0);
      wlord = gen_word();
      if (cur.ready && instr_valid) model_instr(wlord);
      m_sticky = cur.ovf | cur.unf | cur.rerr | (m_sticky & !err_clr);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
